// File: rtl/signed_2_value_pkg.sv
// Shared constants for the signed-to-magnitude converter.
//   SatCountW    : width of the clipped-sample counter
//   WidthMin/Max : legal range of the signed_2_value WIDTH parameter
//   SatCountMax  : saturation ceiling of the clipped-sample counter
package signed_2_value_pkg;

  localparam int unsigned SatCountW = 16;
  localparam int unsigned WidthMin  = 3;
  localparam int unsigned WidthMax  = 32;

  localparam logic [SatCountW-1:0] SatCountMax = '1;

endpackage

// File: rtl/signed_2_value_pipe_stage.sv
// One valid/ready pipeline register with hold-on-backpressure.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   in_valid_i    : upstream has data          in_ready_o  : this stage can take it
//   in_data_i     : upstream data
//   out_valid_o   : stage holds data           out_ready_i : downstream takes it
//   out_data_o    : registered data
module pipe_stage #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              advance;

  // Stage may load when empty or when its content leaves this cycle.
  assign advance     = !valid_q || out_ready_i;
  assign in_ready_o  = rst_ni && advance;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (advance) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/signed_2_value.sv
// Two-stage converter from a two's-complement sample to sign + magnitude.
// The most-negative input is clipped to the largest magnitude and flagged;
// clipped samples delivered downstream are counted in a saturating counter.
//   CLK, RESET          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake, in_value = signed sample
//   out_valid/out_ready : output handshake
//   symbol, abs_value   : sign (1 = negative) and magnitude
//   sat_flag            : this sample's magnitude was clipped
//   sat_clr, sat_count  : clear / count of clipped samples delivered
module signed_2_value
  import signed_2_value_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-2:0]     abs_value,
  output logic                 symbol,
  output logic                 sat_flag,
  input  logic                 sat_clr,
  output logic [SatCountW-1:0] sat_count
);

  if (WIDTH < WidthMin || WIDTH > WidthMax) begin : gen_bad_width
    $error("signed_2_value: WIDTH out of legal range");
  end

  logic             s1_valid, s1_ready;
  logic [WIDTH-1:0] s1_data;
  logic             neg, is_min;
  logic [WIDTH-2:0] mag;
  logic [WIDTH:0]   s2_in, s2_data;

  logic [SatCountW-1:0] sat_count_q, sat_count_d;

  // Stage 1: raw sample (sign bit included).
  pipe_stage #(
    .DATA_W(WIDTH)
  ) u_stage1 (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_value),
    .out_valid_o(s1_valid),
    .out_ready_i(s1_ready),
    .out_data_o (s1_data)
  );

  // Negating only the low WIDTH-1 bits gives the truncated magnitude directly.
  always_comb begin
    neg    = s1_data[WIDTH-1];
    is_min = neg && (s1_data[WIDTH-2:0] == '0);
    mag    = neg ? (~s1_data[WIDTH-2:0] + (WIDTH-1)'(1)) : s1_data[WIDTH-2:0];
    if (is_min) begin
      mag = '1;
    end
    s2_in = {neg, mag, is_min};
  end

  // Stage 2: {symbol, abs_value, sat_flag}.
  pipe_stage #(
    .DATA_W(WIDTH + 1)
  ) u_stage2 (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .in_valid_i (s1_valid),
    .in_ready_o (s1_ready),
    .in_data_i  (s2_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (s2_data)
  );

  assign {symbol, abs_value, sat_flag} = s2_data;

  // Clear wins over a same-cycle increment; the count sticks at its ceiling.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (out_valid && out_ready && sat_flag && (sat_count_q != SatCountMax)) begin
      sat_count_d = sat_count_q + SatCountW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_signed_2_value.sv
// Directed bench for signed_2_value (WIDTH = 8).
module tb_signed_2_value;

  logic        CLK;
  logic        RESET;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_value;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  abs_value;
  logic        symbol;
  logic        sat_flag;
  logic        sat_clr;
  logic [15:0] sat_count;

  int checks   = 0;
  int failures = 0;

  signed_2_value #(
    .WIDTH(8)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_value (in_value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .abs_value(abs_value),
    .symbol   (symbol),
    .sat_flag (sat_flag),
    .sat_clr  (sat_clr),
    .sat_count(sat_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #5000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: {symbol, abs_value, sat_flag} from signed integer arithmetic.
  function automatic logic [8:0] model(input logic [7:0] v);
    int s;
    s = $signed(v);
    if (s < 0) s = -s;
    if (s > 127) return {1'b1, 7'h7f, 1'b1};
    return {v[7], 7'(s), 1'b0};
  endfunction

  logic [7:0] t1_in  [4] = '{8'h05, 8'hfb, 8'h00, 8'hff};
  logic [8:0] t1_exp [4] = '{{1'b0, 7'h05, 1'b0}, {1'b1, 7'h05, 1'b0},
                             {1'b0, 7'h00, 1'b0}, {1'b1, 7'h01, 1'b0}};

  logic [7:0] sb_q[$];

  initial begin
    int         idx;
    int         sent;
    int         rcv;
    int         cyc;
    logic       acc_in, acc_out;
    logic [8:0] got;
    logic [7:0] v, rt;

    RESET    = 1'b0;
    in_valid = 1'b0;
    in_value = 8'h00;
    out_ready = 1'b1;
    sat_clr  = 1'b0;
    step();
    step();

    // Reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {symbol, abs_value, sat_flag}, 0);
    check("rst_sat_count", sat_count, 0);
    RESET = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);

    // Back-to-back stream, latency 2
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4);
      in_value = (i < 4) ? t1_in[i] : 8'h00;
      step();
      if (i == 0) check("stream_lat_empty", out_valid, 0);
      else check("stream_out", {out_valid, symbol, abs_value, sat_flag}, {1'b1, t1_exp[i-1]});
    end
    step();
    check("stream_drained", out_valid, 0);

    // Most-negative input saturates
    check("sat_pre", sat_count, 0);
    in_valid = 1'b1;
    in_value = 8'h80;
    step();
    in_valid = 1'b0;
    step();
    check("sat_out", {out_valid, symbol, abs_value, sat_flag}, {1'b1, 1'b1, 7'h7f, 1'b1});
    check("sat_cnt_before_xfer", sat_count, 0);
    step();
    check("sat_cnt_after_xfer", sat_count, 1);
    check("sat_drained", out_valid, 0);

    // Backpressure: out_ready low for 5 cycles with continuous input
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_value = 8'h11 + 8'(idx);
      #1;
      acc_in = in_ready;
      step();
      if (acc_in) idx++;
      if (c >= 1) check("bp_hold", {out_valid, symbol, abs_value, sat_flag},
                        {1'b1, 1'b0, 7'h11, 1'b0});
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready_low", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_second", {out_valid, abs_value}, {1'b1, 7'h12});
    step();
    check("bp_empty", out_valid, 0);

    // Counter saturation at 0xFFFF
    in_valid = 1'b1;
    in_value = 8'h80;
    repeat (70000) @(posedge CLK);
    #1;
    in_valid = 1'b0;
    step();
    step();
    check("cnt_saturated", sat_count, 16'hffff);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("clr_xfer_pending", {out_valid, sat_flag}, 2'b11);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("clr_priority", sat_count, 0);

    // Reset with two samples in flight
    in_valid = 1'b1;
    in_value = 8'h80;
    step();
    step();
    in_value = 8'h81;
    step();
    check("mid_cnt", sat_count, 1);
    in_valid = 1'b0;
    RESET    = 1'b0;
    #1;
    check("mid_in_ready_low", in_ready, 0);
    step();
    check("mid_out_valid", out_valid, 0);
    check("mid_sat_count", sat_count, 0);
    RESET = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("mid_no_stale", out_valid, 0);
    end

    // Sweep all inputs under random backpressure against the model
    sent = 0;
    rcv  = 0;
    cyc  = 0;
    while (rcv < 256 && cyc < 5000) begin
      in_valid  = (sent < 256) && ($urandom_range(0, 4) != 0);
      in_value  = 8'(sent);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      got     = {symbol, abs_value, sat_flag};
      step();
      cyc++;
      if (acc_in) begin
        sb_q.push_back(8'(sent));
        sent++;
      end
      if (acc_out) begin
        if (sb_q.size() == 0) begin
          check("sweep_unexpected", 1, 0);
        end else begin
          v = sb_q.pop_front();
          check("sweep_model", got, model(v));
          rt = got[8] ? (8'h00 - {1'b0, got[7:1]}) : {1'b0, got[7:1]};
          if (v != 8'h80) check("sweep_roundtrip", rt, v);
        end
        rcv++;
      end
    end
    in_valid = 1'b0;
    check("sweep_count", rcv, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signed_2_value.md
SIGNED_2_VALUE -- requirements
Module: signed_2_value

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bit width of the two's-complement input; legal range 3..32.
REQ-002 SHALL have port CLK  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  input sample present.
REQ-005 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port in_value  input  WIDTH  two's-complement sample.
REQ-007 SHALL have port out_valid  output  1  output sample present.
REQ-008 SHALL have port out_ready  input  1  downstream accepts output this cycle.
REQ-009 SHALL have port abs_value  output  WIDTH-1  magnitude.
REQ-010 SHALL have port symbol  output  1  sign; 1 = negative.
REQ-011 SHALL have port sat_flag  output  1  magnitude of this sample was clipped.
REQ-012 SHALL have port sat_clr  input  1  synchronous clear of sat_count.
REQ-013 SHALL have port sat_count  output  16  number of clipped samples delivered.

Function
REQ-014 SHALL transfer input when in_valid && in_ready on a rising edge, and output when out_valid && out_ready.
REQ-015 SHALL use a 2-stage pipeline: stage 1 registers sign and raw value; stage 2 registers symbol, abs_value and sat_flag.
REQ-016 SHALL have a latency of exactly 2 cycles from input transfer to out_valid with no backpressure, and a throughput of 1 sample per cycle.
REQ-017 SHALL advance each stage when it is empty or the downstream stage transfers in the same cycle; in_ready = !s1_valid || s1 advances, and SHALL NOT depend on in_valid.
REQ-018 SHALL hold out_valid, abs_value, symbol and sat_flag stable while out_valid && !out_ready; no sample is lost or duplicated.
REQ-019 SHALL produce symbol = 0, abs_value = in_value[WIDTH-2:0] and sat_flag = 0 when in_value[WIDTH-1] = 0.
REQ-020 SHALL produce symbol = 1, abs_value = (~in_value + 1) truncated to WIDTH-1 bits and sat_flag = 0 when the input is negative and not the most-negative value.
REQ-021 SHALL produce symbol = 1, abs_value = all ones (2^(WIDTH-1)-1) and sat_flag = 1 for in_value = 1 followed by WIDTH-1 zeros.
REQ-022 SHALL produce symbol = 0 and abs_value = 0 for zero input; negative zero is never emitted.
REQ-023 SHALL increment sat_count by 1 on each output transfer with sat_flag = 1, saturating at 0xFFFF with no wrap.
REQ-024 SHALL have sat_clr take priority over a simultaneous increment, so sat_count = 0 on the next cycle.

Reset
REQ-025 SHALL, with RESET low at a rising edge, clear both stage valid bits, out_valid, abs_value, symbol, sat_flag and sat_count to 0.
REQ-026 SHALL drive in_ready = 0 while RESET is low, and 1 in the first cycle after RESET goes high.
REQ-027 SHALL discard in-flight samples on reset mid-operation; none appear after release.

Structure
REQ-028 SHALL place the sat_count width (16) and the WIDTH legal bounds in the shared DDS package; WIDTH stays a module parameter.
REQ-029 SHALL implement each stage's valid/hold logic as one reusable sub-module pipe_stage (parameter DATA_W), instantiated twice.

Verification
REQ-030 SHALL cover this case with WIDTH = 8 and out_ready held at 1: stream 0x05, 0xFB, 0x00, 0xFF -> (0,0x05,0), (1,0x05,0), (0,0x00,0), (1,0x01,0) on consecutive cycles, each 2 cycles after input.
REQ-031 SHALL cover this case: input 0x80 -> symbol 1, abs_value 0x7F, sat_flag 1, and sat_count goes from 0 to 1.
REQ-032 SHALL cover this case: out_ready low for 5 cycles with continuous input -> in_ready drops after 2 accepted samples, the output is held stable, and on release all samples arrive in order with none lost.
REQ-033 SHALL cover this case: sat_count preset near 0xFFFF by sending 0x80 70000 times -> sat_count stays at 0xFFFF; sat_clr asserted together with an 0x80 transfer -> sat_count = 0.
REQ-034 SHALL cover this case: RESET asserted with 2 samples in flight -> the next cycle has out_valid 0 and sat_count 0, and no stale output appears after release.
REQ-035 SHALL cover this case: random sweep of all 256 inputs under random backpressure -> matches a reference model, and symbol/abs_value round-trip back to in_value (except 0x80).
